// File: rtl/sram_arbiter.sv
// Two-client round-robin arbiter and pin sequencer for a 1Mx16 asynchronous SRAM.
// Every SRAM pin is driven from a register or decoded from the state register alone.
`timescale 1ns/1ps

module sram_arbiter #(
  parameter int WR_PULSE = 1,
  parameter int RD_WAIT  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,

  input  logic        i_c0_req,
  input  logic        i_c0_we,
  input  logic [19:0] i_c0_addr,
  input  logic [15:0] i_c0_wdata,
  output logic        o_c0_ack,
  output logic [15:0] o_c0_rdata,

  input  logic        i_c1_req,
  input  logic        i_c1_we,
  input  logic [19:0] i_c1_addr,
  input  logic [15:0] i_c1_wdata,
  output logic        o_c1_ack,
  output logic [15:0] o_c1_rdata,

  output logic        o_busy,

  output logic [19:0] o_SRAM_ADDR,
  inout  wire  [15:0] io_SRAM_DQ,
  output logic        o_SRAM_CE_N,
  output logic        o_SRAM_OE_N,
  output logic        o_SRAM_WE_N,
  output logic        o_SRAM_LB_N,
  output logic        o_SRAM_UB_N
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WR,
    S_WR_HOLD,
    S_RD,
    S_ACK
  } state_t;

  localparam int                CNT_W   = 8;
  localparam logic [CNT_W-1:0]  WR_LAST = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0]  RD_LAST = CNT_W'(RD_WAIT - 1);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;

  logic               r_gnt;     // client owning the current transaction
  logic               r_prio;    // client that wins the next tie
  logic               r_we;
  logic [19:0]        r_addr;
  logic [15:0]        r_wdata;
  logic [15:0]        r_c0_rdata;
  logic [15:0]        r_c1_rdata;

  logic               w_any_req;
  logic               w_gnt_sel;
  logic               w_wr_last;
  logic               w_rd_last;
  logic               w_dq_oe;

  assign w_any_req = i_c0_req | i_c1_req;
  assign w_gnt_sel = (i_c0_req & i_c1_req) ? r_prio : i_c1_req;
  assign w_wr_last = (r_cnt == WR_LAST);
  assign w_rd_last = (r_cnt == RD_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_next      = r_state;
    o_SRAM_CE_N = 1'b1;
    o_SRAM_OE_N = 1'b1;
    o_SRAM_WE_N = 1'b1;
    w_dq_oe     = 1'b0;
    o_c0_ack    = 1'b0;
    o_c1_ack    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) w_next = S_ADDR;
      end
      S_ADDR: begin
        o_SRAM_CE_N = 1'b0;
        w_dq_oe     = r_we;
        w_next      = r_we ? S_WR : S_RD;
      end
      S_WR: begin
        o_SRAM_CE_N = 1'b0;
        o_SRAM_WE_N = 1'b0;
        w_dq_oe     = 1'b1;
        if (w_wr_last) w_next = S_WR_HOLD;
      end
      S_WR_HOLD: begin
        o_SRAM_CE_N = 1'b0;
        w_dq_oe     = 1'b1;
        w_next      = S_ACK;
      end
      S_RD: begin
        o_SRAM_CE_N = 1'b0;
        o_SRAM_OE_N = 1'b0;
        if (w_rd_last) w_next = S_ACK;
      end
      S_ACK: begin
        o_c0_ack = ~r_gnt;
        o_c1_ack = r_gnt;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Pulse-width counter restarts on every state change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (r_state == S_WR || r_state == S_RD) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Request fields are captured once at grant; later input changes are ignored.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gnt   <= 1'b0;
      r_prio  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_gnt   <= w_gnt_sel;
      r_prio  <= ~w_gnt_sel;
      r_we    <= w_gnt_sel ? i_c1_we    : i_c0_we;
      r_addr  <= w_gnt_sel ? i_c1_addr  : i_c0_addr;
      r_wdata <= w_gnt_sel ? i_c1_wdata : i_c0_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_c0_rdata <= '0;
      r_c1_rdata <= '0;
    end else if (r_state == S_RD && w_rd_last) begin
      if (r_gnt) r_c1_rdata <= io_SRAM_DQ;
      else       r_c0_rdata <= io_SRAM_DQ;
    end
  end

  assign o_c0_rdata  = r_c0_rdata;
  assign o_c1_rdata  = r_c1_rdata;
  assign o_busy      = (r_state != S_IDLE);
  assign o_SRAM_ADDR = r_addr;
  assign o_SRAM_LB_N = o_SRAM_CE_N;
  assign o_SRAM_UB_N = o_SRAM_CE_N;
  assign io_SRAM_DQ  = w_dq_oe ? r_wdata : 16'hzzzz;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default-timing instance with an SRAM model,
// plus a second instance with stretched write/read strobes.
`timescale 1ns/1ps

module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- default instance ----------------
  logic        c0_req, c0_we, c1_req, c1_we;
  logic [19:0] c0_addr, c1_addr;
  logic [15:0] c0_wdata, c1_wdata;
  wire         c0_ack, c1_ack, busy;
  wire  [15:0] c0_rdata, c1_rdata;
  wire  [19:0] sram_addr;
  wire  [15:0] sram_dq;
  wire         ce_n, oe_n, we_n, lb_n, ub_n;

  sram_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_c0_req(c0_req), .i_c0_we(c0_we), .i_c0_addr(c0_addr), .i_c0_wdata(c0_wdata),
    .o_c0_ack(c0_ack), .o_c0_rdata(c0_rdata),
    .i_c1_req(c1_req), .i_c1_we(c1_we), .i_c1_addr(c1_addr), .i_c1_wdata(c1_wdata),
    .o_c1_ack(c1_ack), .o_c1_rdata(c1_rdata),
    .o_busy(busy),
    .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(sram_dq),
    .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n), .o_SRAM_WE_N(we_n),
    .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
  );

  // SRAM model: writes land while WE_N is low, reads drive DQ while OE_N is low.
  logic [15:0] mem [logic [19:0]];
  logic [15:0] mem_q = 16'h0000;
  always @(negedge oe_n) mem_q = mem.exists(sram_addr) ? mem[sram_addr] : 16'hDEAD;
  always @(negedge clk) if (!ce_n && !we_n) mem[sram_addr] = sram_dq;
  assign sram_dq = (!ce_n && !oe_n) ? mem_q : 16'hzzzz;

  // ---------------- stretched-strobe instance ----------------
  logic        p_c0_req, p_c0_we, p_c1_req, p_c1_we;
  logic [19:0] p_c0_addr, p_c1_addr;
  logic [15:0] p_c0_wdata, p_c1_wdata;
  wire         p_c0_ack, p_c1_ack, p_busy;
  wire  [15:0] p_c0_rdata, p_c1_rdata;
  wire  [19:0] p_addr;
  wire  [15:0] p_dq;
  wire         p_ce_n, p_oe_n, p_we_n, p_lb_n, p_ub_n;

  sram_arbiter #(.WR_PULSE(3), .RD_WAIT(2)) dut_p (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_c0_req(p_c0_req), .i_c0_we(p_c0_we), .i_c0_addr(p_c0_addr), .i_c0_wdata(p_c0_wdata),
    .o_c0_ack(p_c0_ack), .o_c0_rdata(p_c0_rdata),
    .i_c1_req(p_c1_req), .i_c1_we(p_c1_we), .i_c1_addr(p_c1_addr), .i_c1_wdata(p_c1_wdata),
    .o_c1_ack(p_c1_ack), .o_c1_rdata(p_c1_rdata),
    .o_busy(p_busy),
    .o_SRAM_ADDR(p_addr), .io_SRAM_DQ(p_dq),
    .o_SRAM_CE_N(p_ce_n), .o_SRAM_OE_N(p_oe_n), .o_SRAM_WE_N(p_we_n),
    .o_SRAM_LB_N(p_lb_n), .o_SRAM_UB_N(p_ub_n)
  );

  assign p_dq = (!p_ce_n && !p_oe_n) ? 16'hA5C3 : 16'hzzzz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe width / capture monitors, sampled on the falling edge.
  int          we_cnt = 0, we_w = 0, oe_cnt = 0, oe_w = 0;
  logic [15:0] wr_dq_cap = '0, prev_dq = '0;
  logic [19:0] wr_addr_cap = '0, prev_addr = '0;
  bit          prev_we_low = 1'b0;
  int          p_we_cnt = 0, p_we_w = 0, p_oe_cnt = 0, p_oe_w = 0;
  logic [15:0] p_wr_dq = '0;
  logic [19:0] p_wr_addr = '0;

  always @(negedge clk) begin
    if (!we_n) begin
      we_cnt++; wr_dq_cap = sram_dq; wr_addr_cap = sram_addr;
    end else if (we_cnt != 0) begin
      we_w = we_cnt; we_cnt = 0;
    end
    if (!oe_n) oe_cnt++;
    else if (oe_cnt != 0) begin oe_w = oe_cnt; oe_cnt = 0; end

    if (!oe_n) check("dq_driven_while_oe", {31'd0, dut.w_dq_oe}, 32'd0);
    if (!p_oe_n) check("p_dq_driven_while_oe", {31'd0, dut_p.w_dq_oe}, 32'd0);
    if (rst_n && !we_n) check("addr_stable_we_low", sram_addr, prev_addr);
    if (rst_n && prev_we_low && we_n) begin
      check("addr_hold_after_we", sram_addr, prev_addr);
      check("dq_hold_after_we", sram_dq, prev_dq);
    end
    prev_addr   = sram_addr;
    prev_dq     = sram_dq;
    prev_we_low = !we_n;

    if (!p_we_n) begin
      p_we_cnt++; p_wr_dq = p_dq; p_wr_addr = p_addr;
    end else if (p_we_cnt != 0) begin
      p_we_w = p_we_cnt; p_we_cnt = 0;
    end
    if (!p_oe_n) p_oe_cnt++;
    else if (p_oe_cnt != 0) begin p_oe_w = p_oe_cnt; p_oe_cnt = 0; end
  end

  // One transaction from one client; lat counts edges from request to ack.
  task automatic txn(input string tag, input bit c, input bit we, input logic [19:0] a,
                     input logic [15:0] d, input int lat, input logic [15:0] exp_rd);
    int          n;
    bit          got;
    logic [15:0] other_rd;
    other_rd = c ? c0_rdata : c1_rdata;
    we_w = 0; oe_w = 0;
    if (c) begin c1_req = 1; c1_we = we; c1_addr = a; c1_wdata = d; end
    else   begin c0_req = 1; c0_we = we; c0_addr = a; c0_wdata = d; end
    n = 0; got = 0;
    while (!got && n < 20) begin
      tick(); n++;
      got = c ? c1_ack : c0_ack;
      check({tag, "_other_ack"}, {31'd0, (c ? c0_ack : c1_ack)}, 32'd0);
    end
    check({tag, "_latency"}, n, lat);
    check({tag, "_busy_at_ack"}, {31'd0, busy}, 32'd1);
    if (!we) check({tag, "_rdata"}, c ? c1_rdata : c0_rdata, exp_rd);
    if (c) c1_req = 0; else c0_req = 0;
    tick();
    check({tag, "_other_rdata"}, c ? c0_rdata : c1_rdata, other_rd);
    check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    if (we) begin
      check({tag, "_we_width"}, we_w, 1);
      check({tag, "_wr_dq"}, wr_dq_cap, d);
      check({tag, "_wr_addr"}, wr_addr_cap, a);
      check({tag, "_no_oe"}, oe_w, 0);
    end else begin
      check({tag, "_oe_width"}, oe_w, 1);
      check({tag, "_no_we"}, we_w, 0);
    end
  endtask

  initial begin
    int          n, k;
    bit          got;
    int          ack_n [4];
    bit          ack_c [4];
    logic [15:0] exp_mem [4];
    logic [15:0] d;
    int          slot;
    bit          c, we;

    rst_n = 0;
    c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0;
    c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;
    p_c0_req = 0; p_c0_we = 0; p_c0_addr = '0; p_c0_wdata = '0;
    p_c1_req = 0; p_c1_we = 0; p_c1_addr = '0; p_c1_wdata = '0;
    mem[20'd671999] = 16'hBEEF;
    mem[20'h00100]  = 16'h1111;
    mem[20'h00200]  = 16'h2222;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_strobes", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
    check("rst_addr", sram_addr, 32'd0);
    check("rst_acks", {30'd0, c0_ack, c1_ack}, 32'd0);
    check("rst_c0_rdata", c0_rdata, 32'd0);
    check("rst_c1_rdata", c1_rdata, 32'd0);
    rst_n = 1;
    tick();

    txn("wr_c0",   1'b0, 1'b1, 20'd32000,  16'h1234, 4, 16'h0000);
    txn("rd_c1",   1'b1, 1'b0, 20'd671999, 16'h0000, 3, 16'hBEEF);
    txn("rd_c0",   1'b0, 1'b0, 20'd32000,  16'h0000, 3, 16'h1234);
    txn("wr_top",  1'b1, 1'b1, 20'hFFFFF,  16'hCAFE, 4, 16'h0000);
    txn("rd_top",  1'b0, 1'b0, 20'hFFFFF,  16'h0000, 3, 16'hCAFE);
    txn("rd_c1b",  1'b1, 1'b0, 20'h00200,  16'h0000, 3, 16'h2222);

    // Both clients hold read requests; last grant was c1 so c0 wins first.
    for (int i = 0; i < 4; i++) begin ack_n[i] = -1; ack_c[i] = 1'b0; end
    c0_req = 1; c0_we = 0; c0_addr = 20'h00100;
    c1_req = 1; c1_we = 0; c1_addr = 20'd671999;
    n = 0; k = 0;
    while (k < 4 && n < 40) begin
      tick(); n++;
      if (c0_ack || c1_ack) begin
        check("cont_single_ack", {31'd0, (c0_ack & c1_ack)}, 32'd0);
        ack_n[k] = n; ack_c[k] = c1_ack; k++;
      end
    end
    c0_req = 0; c1_req = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cont_client_%0d", i), {31'd0, ack_c[i]}, i % 2);
      check($sformatf("cont_cycle_%0d", i), ack_n[i], 3 + 4 * i);
    end
    check("cont_c0_rdata", c0_rdata, 32'h1111);
    check("cont_c1_rdata", c1_rdata, 32'hBEEF);
    tick();

    // Random mixed single-client traffic over four scratch addresses.
    for (int i = 0; i < 4; i++) begin
      exp_mem[i] = 16'($urandom);
      txn($sformatf("init_%0d", i), i[0], 1'b1, 20'h40000 + 20'(i), exp_mem[i], 4, 16'h0000);
    end
    for (int i = 0; i < 12; i++) begin
      c    = 1'($urandom_range(1));
      we   = 1'($urandom_range(1));
      slot = int'($urandom_range(3));
      if (we) begin
        d = 16'($urandom);
        txn($sformatf("rnd_wr_%0d", i), c, 1'b1, 20'h40000 + 20'(slot), d, 4, 16'h0000);
        exp_mem[slot] = d;
      end else begin
        txn($sformatf("rnd_rd_%0d", i), c, 1'b0, 20'h40000 + 20'(slot), 16'h0000, 3, exp_mem[slot]);
      end
    end

    // Reset in the middle of a write; c0 grant leaves the pointer at c1.
    c0_req = 1; c0_we = 1; c0_addr = 20'h00ABC; c0_wdata = 16'hFFFF;
    tick();
    tick();
    check("mid_wr_we_low", {31'd0, we_n}, 32'd0);
    rst_n = 0;
    #1;
    check("mid_rst_strobes", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
    check("mid_rst_addr", sram_addr, 32'd0);
    check("mid_rst_dq_off", {31'd0, dut.w_dq_oe}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_c0_rdata", c0_rdata, 32'd0);
    check("mid_rst_c1_rdata", c1_rdata, 32'd0);
    c0_req = 0;
    @(negedge clk);
    #2;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_ack", {30'd0, c0_ack, c1_ack}, 32'd0);
      check("post_rst_idle", {31'd0, busy}, 32'd0);
    end

    // Fresh contention: pointer is back at c0.
    c0_req = 1; c0_we = 0; c0_addr = 20'd32000;
    c1_req = 1; c1_we = 0; c1_addr = 20'd671999;
    n = 0; got = 0;
    while (!got && n < 20) begin
      tick(); n++;
      got = c0_ack | c1_ack;
    end
    check("post_rst_first_c0", {30'd0, c0_ack, c1_ack}, 32'h2);
    check("post_rst_first_lat", n, 3);
    check("post_rst_c0_rdata", c0_rdata, 32'h1234);
    c0_req = 0;
    got = 0;
    while (!got && n < 20) begin
      tick(); n++;
      got = c1_ack;
    end
    check("post_rst_c1_lat", n, 7);
    check("post_rst_c1_rdata", c1_rdata, 32'hBEEF);
    c1_req = 0;
    tick();
    txn("post_rst_wr", 1'b1, 1'b1, 20'h00ABD, 16'h5A5A, 4, 16'h0000);

    // Stretched instance: WR_PULSE=3, RD_WAIT=2.
    p_c0_req = 1; p_c0_we = 1; p_c0_addr = 20'h00010; p_c0_wdata = 16'h7E81;
    p_we_w = 0;
    n = 0; got = 0;
    while (!got && n < 30) begin
      tick(); n++;
      got = p_c0_ack;
    end
    check("p_wr_latency", n, 6);
    p_c0_req = 0;
    tick();
    check("p_we_width", p_we_w, 3);
    check("p_wr_dq", p_wr_dq, 32'h7E81);
    check("p_wr_addr", p_wr_addr, 32'h00010);
    check("p_idle", {31'd0, p_busy}, 32'd0);

    p_c0_req = 1; p_c0_we = 0; p_c0_addr = 20'h00020;
    p_oe_w = 0;
    n = 0; got = 0;
    while (!got && n < 30) begin
      tick(); n++;
      got = p_c0_ack;
    end
    check("p_rd_latency", n, 4);
    check("p_rd_rdata", p_c0_rdata, 32'hA5C3);
    check("p_c1_untouched", p_c1_rdata, 32'd0);
    p_c0_req = 0;
    tick();
    check("p_oe_width", p_oe_w, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
